// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch unit.
// Holds the architectural PC and reads one instruction word per PC over an AXI4-Lite-style
// read channel. It offers the word downstream, then waits for the writeback next-PC
// before fetching again. At most one read is ever outstanding.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    // AR channel
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    // R channel
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // F->D stage handshake
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        m_valid,
    input  logic        m_ready,
    // Next-PC update from writeback
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic        npc_ready,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        StReq     = 2'd0,
        StResp    = 2'd1,
        StSend    = 2'd2,
        StWaitNpc = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        err_q;

    // FSM, PC, instruction and sticky error; handshake inputs only matter in their own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (arready) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (rvalid) begin
                        inst_q  <= rdata;
                        // The word is still forwarded on error; only the flag records it.
                        if (rresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (m_ready) begin
                        state_q <= StWaitNpc;
                    end
                end
                StWaitNpc: begin
                    if (npc_valid) begin
                        pc_q    <= npc;
                        // A misaligned target is flagged but fetched anyway.
                        if (npc[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

    // Moore handshake outputs decoded purely from the state register.
    always_comb begin
        arvalid   = (state_q == StReq);
        rready    = (state_q == StResp);
        m_valid   = (state_q == StSend);
        npc_ready = (state_q == StWaitNpc);
    end

    assign araddr    = pc_q;
    assign pcF       = pc_q;
    assign snpcF     = pc_q + 32'd4;
    assign instF     = inst_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed-vector bench for ifu_fetch with hand-computed expectations.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic [31:0] snpcF;
    logic        m_valid;
    logic        m_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic        npc_ready;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;

    ifu_fetch #(
        .RESET_PC(32'h80000000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .instF    (instF),
        .pcF      (pcF),
        .snpcF    (snpcF),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .npc_valid(npc_valid),
        .npc      (npc),
        .npc_ready(npc_ready),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs that identify the state: {arvalid, rready, m_valid, npc_ready}.
    function automatic logic [31:0] hs();
        return {28'd0, arvalid, rready, m_valid, npc_ready};
    endfunction

    localparam logic [31:0] HsReq  = 32'h8;
    localparam logic [31:0] HsResp = 32'h4;
    localparam logic [31:0] HsSend = 32'h2;
    localparam logic [31:0] HsWait = 32'h1;

    initial begin
        rst       = 1'b1;
        arready   = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rvalid    = 1'b0;
        m_ready   = 1'b0;
        npc_valid = 1'b0;
        npc       = '0;

        // Reset values, observed while rst is still high.
        tick();
        tick();
        chk("rst_hs", hs(), HsReq);
        chk("rst_pc", pcF, 32'h80000000);
        chk("rst_snpc", snpcF, 32'h80000004);
        chk("rst_inst", instF, 32'h0);
        chk("rst_err", {31'd0, fetch_err}, 32'h0);
        chk("rst_araddr", araddr, 32'h80000000);
        rst = 1'b0;

        // Zero-wait loop: 4 cycles per instruction.
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h00000413;
        m_ready   = 1'b1;
        npc_valid = 1'b1;
        npc       = 32'h80000100;
        tick();
        chk("zw_resp", hs(), HsResp);
        tick();
        chk("zw_send", hs(), HsSend);
        chk("zw_inst", instF, 32'h00000413);
        chk("zw_pc", pcF, 32'h80000000);
        chk("zw_snpc", snpcF, 32'h80000004);
        tick();
        chk("zw_wait", hs(), HsWait);
        tick();
        chk("zw_req", hs(), HsReq);
        chk("zw_araddr", araddr, 32'h80000100);

        // Delayed arready (3 cycles) and rvalid (2 cycles).
        arready   = 1'b0;
        rvalid    = 1'b0;
        m_ready   = 1'b0;
        npc_valid = 1'b0;
        rdata     = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_hold_hs", hs(), HsReq);
            chk("ar_hold_addr", araddr, 32'h80000100);
        end
        arready = 1'b1;
        tick();
        chk("ar_done", hs(), HsResp);
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("r_wait_hs", hs(), HsResp);
            chk("r_wait_inst", instF, 32'h00000413);
        end
        rvalid = 1'b1;
        rdata  = 32'h12345678;
        tick();
        chk("r_done_hs", hs(), HsSend);
        chk("r_done_inst", instF, 32'h12345678);
        rvalid = 1'b0;
        rdata  = 32'hBADBAD00;

        // Downstream stall with stray npc_valid pulses.
        npc       = 32'h00000055;
        for (int i = 0; i < 5; i++) begin
            npc_valid = (i % 2 == 0);
            tick();
            chk("stall_hs", hs(), HsSend);
            chk("stall_inst", instF, 32'h12345678);
            chk("stall_pc", pcF, 32'h80000100);
        end
        npc_valid = 1'b0;
        m_ready   = 1'b1;
        tick();
        chk("send_done", hs(), HsWait);
        chk("wait_pc", pcF, 32'h80000100);
        m_ready = 1'b0;

        // PC wrap.
        npc       = 32'hFFFFFFFC;
        npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        chk("wrap_hs", hs(), HsReq);
        chk("wrap_pc", pcF, 32'hFFFFFFFC);
        chk("wrap_snpc", snpcF, 32'h00000000);
        chk("wrap_err", {31'd0, fetch_err}, 32'h0);

        // OKAY fetch at the wrapped PC, then a misaligned npc.
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h00100073;
        tick();
        rvalid  = 1'b0;
        chk("wrapf_inst", instF, 32'h00100073);
        m_ready = 1'b1;
        tick();
        m_ready   = 1'b0;
        npc       = 32'h80000102;
        npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        chk("mis_hs", hs(), HsReq);
        chk("mis_araddr", araddr, 32'h80000102);
        chk("mis_err", {31'd0, fetch_err}, 32'h1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("mis_resp", hs(), HsResp);

        // Reset with an R beat in flight: beat dropped, everything back to reset values.
        rvalid = 1'b1;
        rdata  = 32'hFFFF0000;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        rvalid = 1'b0;
        chk("rr_hs", hs(), HsReq);
        chk("rr_pc", pcF, 32'h80000000);
        chk("rr_inst", instF, 32'h0);
        chk("rr_err", {31'd0, fetch_err}, 32'h0);

        // SLVERR response: flagged, instruction still offered.
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rresp   = 2'b10;
        rdata   = 32'hCAFEF00D;
        tick();
        rvalid  = 1'b0;
        rresp   = 2'b00;
        chk("slv_hs", hs(), HsSend);
        chk("slv_inst", instF, 32'hCAFEF00D);
        chk("slv_err", {31'd0, fetch_err}, 32'h1);

        // Error stays sticky through a later OKAY fetch.
        m_ready = 1'b1;
        tick();
        m_ready   = 1'b0;
        npc       = 32'h80000200;
        npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        chk("stk_pc", pcF, 32'h80000200);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h00000001;
        tick();
        rvalid  = 1'b0;
        chk("stk_hs", hs(), HsSend);
        chk("stk_inst", instF, 32'h00000001);
        chk("stk_err", {31'd0, fetch_err}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
